alu_result_display: RTL and testbench

Output-side sequencer for the ALU bench board. It accepts one ALU result (16-bit value, 4 flags, 4-bit opcode) per handshake and steps the 16-bit LED display through the result word and then the flag/opcode word. Steps come from a push-button edge or an optional auto-advance timer. It is the read-back counterpart of the operand-entry sequencer: the ALU sits between them and raises `res_valid` when its `doCal`-triggered computation completes.

---
 rtl/alu_result_display_if.sv | 26 ++
 rtl/alu_result_display.sv | 130 +++++++++++++
 tb/tb_alu_result_display.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_display_if.sv
// Result handshake between the ALU and the read-back display sequencer.
// The ALU side (master) offers a result word with its flags and opcode;
// the display side (slave) answers with res_ready when it can capture one.
interface alu_result_display_if;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] result;
  logic [3:0]  flags;
  logic [3:0]  op;

  modport master (
    output res_valid,
    output result,
    output flags,
    output op,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  result,
    input  flags,
    input  op,
    output res_ready
  );
endinterface

// File: rtl/alu_result_display.sv
// Read-back sequencer for the ALU bench board. Captures one ALU result per
// handshake, then walks the 16-bit LED display through the result word and
// the {op, flags} word. Each step comes from a rising edge of the debounced
// push button or from the optional auto-advance timer. Finishing a sequence
// bumps the completed-result counter, which the display shows while idle.
module alu_result_display #(
  parameter int AUTO_CYC = 0,
  parameter int CNTW     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_result_display_if.slave  bus,
  input  logic                 step,
  output logic [15:0]          disp,
  output logic [1:0]           disp_sel,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RES  = 2'd1,
    FLAG = 2'd2
  } state_t;

  // The hold counter only has to reach AUTO_CYC-1; keep at least one bit so
  // the design still elaborates when auto-advance is disabled.
  localparam int HW = (AUTO_CYC > 1) ? $clog2(AUTO_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((AUTO_CYC > 0) ? AUTO_CYC - 1 : 0);

  state_t          state;
  state_t          state_next;
  logic            step_d;
  logic            step_edge;
  logic            auto_hit;
  logic            adv;
  logic [HW-1:0]   hold;
  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] cnt_next;
  logic [15:0]     res_s;
  logic [3:0]      flags_s;
  logic [3:0]      op_s;
  logic            capture;
  logic            inc_cnt;
  logic            done_next;
  logic [15:0]     disp_next;

  assign step_edge = step & ~step_d;
  assign auto_hit  = (AUTO_CYC != 0) && (hold == HOLD_LAST);
  assign adv       = step_edge | auto_hit;

  // Status outputs are decoded straight from the state register.
  assign bus.res_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign disp_sel      = (state == RES)  ? 2'b01 :
                         (state == FLAG) ? 2'b10 : 2'b00;

  // Next-state, capture/count strobes and the next display word.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    inc_cnt    = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.res_valid) begin
          state_next = RES;
          capture    = 1'b1;
        end
      end
      RES: begin
        if (adv) begin
          state_next = FLAG;
        end
      end
      FLAG: begin
        if (adv) begin
          state_next = IDLE;
          done_next  = 1'b1;
          inc_cnt    = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    cnt_next = inc_cnt ? cnt + CNTW'(1) : cnt;

    disp_next = 16'h0000;
    case (state_next)
      IDLE:    disp_next = 16'(cnt_next);
      RES:     disp_next = capture ? bus.result : res_s;
      FLAG:    disp_next = {op_s, 8'h00, flags_s};
      default: disp_next = 16'h0000;
    endcase
  end

  // State, counters, snapshots and registered display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      step_d  <= 1'b1;
      hold    <= '0;
      cnt     <= '0;
      res_s   <= 16'h0000;
      flags_s <= 4'h0;
      op_s    <= 4'h0;
      disp    <= 16'h0000;
      done    <= 1'b0;
    end else begin
      state  <= state_next;
      step_d <= step;
      cnt    <= cnt_next;
      disp   <= disp_next;
      done   <= done_next;
      if (state_next != state) begin
        hold <= '0;
      end else if (state != IDLE) begin
        hold <= hold + HW'(1);
      end
      if (capture) begin
        res_s   <= bus.result;
        flags_s <= bus.flags;
        op_s    <= bus.op;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_display.sv
// Directed bench for alu_result_display. Two instances: one step-driven
// (auto-advance off) and one with a 4-cycle auto-advance timer.
module tb_alu_result_display;

  logic        clk;
  logic        rst;
  logic        step0;
  logic        step1;
  logic [15:0] disp0;
  logic [15:0] disp1;
  logic [1:0]  sel0;
  logic [1:0]  sel1;
  logic        busy0;
  logic        busy1;
  logic        done0;
  logic        done1;

  int errors;
  int checks;
  int done_seen;

  alu_result_display_if if0();
  alu_result_display_if if1();

  alu_result_display #(.AUTO_CYC(0), .CNTW(8)) u0 (
    .clk      (clk),
    .rst      (rst),
    .bus      (if0),
    .step     (step0),
    .disp     (disp0),
    .disp_sel (sel0),
    .busy     (busy0),
    .done     (done0)
  );

  alu_result_display #(.AUTO_CYC(4), .CNTW(8)) u1 (
    .clk      (clk),
    .rst      (rst),
    .bus      (if1),
    .step     (step1),
    .disp     (disp1),
    .disp_sel (sel1),
    .busy     (busy1),
    .done     (done1)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts done pulses of the step-driven instance.
  initial done_seen = 0;
  always @(negedge clk) begin
    if (done0 === 1'b1) done_seen = done_seen + 1;
  end

  // Guards against a hung run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step0 = 1'b1;
    step1 = 1'b1;
    if0.res_valid = 1'b0; if0.result = 16'h0; if0.flags = 4'h0; if0.op = 4'h0;
    if1.res_valid = 1'b0; if1.result = 16'h0; if1.flags = 4'h0; if1.op = 4'h0;
    tick();
    tick();
    checks++;
    if (disp0 !== 16'h0000) begin errors++; $display("[TB] FAIL reset_disp: got %h want 0000", disp0); end
    checks++;
    if (sel0 !== 2'b00 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_status: got sel=%b busy=%b done=%b want 00 0 0", sel0, busy0, done0);
    end
    checks++;
    if (if0.res_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b want 1", if0.res_ready); end
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (disp0 !== 16'h0000 || sel0 !== 2'b00 || if0.res_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL held_step_release: got disp=%h sel=%b ready=%b want 0000 00 1", disp0, sel0, if0.res_ready);
    end
    step0 = 1'b0;
    step1 = 1'b0;
    tick();
  endtask

  task automatic test_capture_step();
    if0.result = 16'hBEEF; if0.flags = 4'b0101; if0.op = 4'h3; if0.res_valid = 1'b1;
    tick();
    if0.res_valid = 1'b0;
    checks++;
    if (disp0 !== 16'hBEEF || sel0 !== 2'b01) begin
      errors++; $display("[TB] FAIL capture_disp: got %h sel=%b want beef 01", disp0, sel0);
    end
    checks++;
    if (busy0 !== 1'b1 || if0.res_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL capture_status: got busy=%b ready=%b want 1 0", busy0, if0.res_ready);
    end
    step0 = 1'b1;
    tick();
    checks++;
    if (disp0 !== 16'h3005 || sel0 !== 2'b10) begin
      errors++; $display("[TB] FAIL step_to_flag: got %h sel=%b want 3005 10", disp0, sel0);
    end
    tick();
    checks++;
    if (disp0 !== 16'h3005 || sel0 !== 2'b10) begin
      errors++; $display("[TB] FAIL step_level_hold: got %h sel=%b want 3005 10", disp0, sel0);
    end
    step0 = 1'b0;
    tick();
    step0 = 1'b1;
    tick();
    checks++;
    if (done0 !== 1'b1 || disp0 !== 16'h0001 || sel0 !== 2'b00) begin
      errors++; $display("[TB] FAIL step_to_idle: got done=%b disp=%h sel=%b want 1 0001 00", done0, disp0, sel0);
    end
    step0 = 1'b0;
    tick();
    checks++;
    if (done0 !== 1'b0) begin errors++; $display("[TB] FAIL done_width: got %b want 0", done0); end
  endtask

  task automatic test_back_to_back();
    if0.result = 16'hBEEF; if0.flags = 4'b0101; if0.op = 4'h3; if0.res_valid = 1'b1;
    tick();
    if0.result = 16'h1234; if0.flags = 4'hF; if0.op = 4'h9;
    tick();
    tick();
    checks++;
    if (if0.res_ready !== 1'b0 || disp0 !== 16'hBEEF) begin
      errors++; $display("[TB] FAIL ignore_valid_in_res: got ready=%b disp=%h want 0 beef", if0.res_ready, disp0);
    end
    step0 = 1'b1;
    tick();
    step0 = 1'b0;
    checks++;
    if (disp0 !== 16'h3005) begin errors++; $display("[TB] FAIL snapshot_stable: got %h want 3005", disp0); end
    tick();
    step0 = 1'b1;
    tick();
    step0 = 1'b0;
    checks++;
    if (done0 !== 1'b1 || if0.res_ready !== 1'b1 || disp0 !== 16'h0002) begin
      errors++; $display("[TB] FAIL done_ready: got done=%b ready=%b disp=%h want 1 1 0002", done0, if0.res_ready, disp0);
    end
    tick();
    if0.res_valid = 1'b0;
    checks++;
    if (disp0 !== 16'h1234 || sel0 !== 2'b01) begin
      errors++; $display("[TB] FAIL b2b_capture: got %h sel=%b want 1234 01", disp0, sel0);
    end
    step0 = 1'b1;
    tick();
    step0 = 1'b0;
    checks++;
    if (disp0 !== 16'h900F) begin errors++; $display("[TB] FAIL b2b_flag: got %h want 900f", disp0); end
    tick();
    step0 = 1'b1;
    tick();
    step0 = 1'b0;
    checks++;
    if (disp0 !== 16'h0003) begin errors++; $display("[TB] FAIL b2b_count: got %h want 0003", disp0); end
    tick();
  endtask

  task automatic test_auto();
    if1.result = 16'h00FF; if1.flags = 4'b1010; if1.op = 4'hC; if1.res_valid = 1'b1;
    tick();
    if1.res_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if (sel1 !== ((c <= 4) ? 2'b01 : 2'b10) || disp1 !== ((c <= 4) ? 16'h00FF : 16'hC00A) || done1 !== 1'b0) begin
        errors++; $display("[TB] FAIL auto_cycle%0d: got sel=%b disp=%h done=%b", c, sel1, disp1, done1);
      end
      tick();
    end
    checks++;
    if (done1 !== 1'b1 || disp1 !== 16'h0001 || sel1 !== 2'b00) begin
      errors++; $display("[TB] FAIL auto_done: got done=%b disp=%h sel=%b want 1 0001 00", done1, disp1, sel1);
    end
    tick();
    if1.res_valid = 1'b1;
    tick();
    if1.res_valid = 1'b0;
    tick();
    tick();
    tick();
    step1 = 1'b1;
    checks++;
    if (sel1 !== 2'b01) begin errors++; $display("[TB] FAIL coincide_pre: got sel=%b want 01", sel1); end
    tick();
    checks++;
    if (sel1 !== 2'b10 || disp1 !== 16'hC00A) begin
      errors++; $display("[TB] FAIL coincide_single: got sel=%b disp=%h want 10 c00a", sel1, disp1);
    end
    tick();
    tick();
    tick();
    checks++;
    if (sel1 !== 2'b10) begin errors++; $display("[TB] FAIL coincide_flag_len: got sel=%b want 10", sel1); end
    tick();
    checks++;
    if (done1 !== 1'b1 || disp1 !== 16'h0002) begin
      errors++; $display("[TB] FAIL coincide_done: got done=%b disp=%h want 1 0002", done1, disp1);
    end
    step1 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int pulses;
    if0.result = 16'h5A5A; if0.res_valid = 1'b1;
    tick();
    if0.res_valid = 1'b0;
    step0 = 1'b1;
    tick();
    step0 = 1'b0;
    checks++;
    if (sel0 !== 2'b10) begin errors++; $display("[TB] FAIL mid_in_flag: got sel=%b want 10", sel0); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (disp0 !== 16'h0000 || busy0 !== 1'b0 || sel0 !== 2'b00 || if0.res_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL async_reset: got disp=%h busy=%b sel=%b ready=%b", disp0, busy0, sel0, if0.res_ready);
    end
    pulses = done_seen;
    tick();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (disp0 !== 16'h0000 || done_seen != pulses) begin
      errors++; $display("[TB] FAIL mid_no_count: got disp=%h done_pulses=%0d want 0000 0", disp0, done_seen - pulses);
    end
  endtask

  task automatic test_wrap();
    int start;
    start = done_seen;
    if0.result = 16'hCAFE; if0.flags = 4'h1; if0.op = 4'h2;
    for (int n = 1; n <= 256; n++) begin
      if0.res_valid = 1'b1;
      tick();
      if0.res_valid = 1'b0;
      step0 = 1'b1;
      tick();
      step0 = 1'b0;
      tick();
      step0 = 1'b1;
      tick();
      step0 = 1'b0;
      tick();
      if (n == 255) begin
        checks++;
        if (disp0 !== 16'h00FF) begin errors++; $display("[TB] FAIL wrap_255: got %h want 00ff", disp0); end
      end
    end
    checks++;
    if (disp0 !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_256: got %h want 0000", disp0); end
    checks++;
    if (done_seen - start != 256) begin
      errors++; $display("[TB] FAIL wrap_done_count: got %0d want 256", done_seen - start);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    $display("[TB] starting alu_result_display bench");
    test_reset();
    test_capture_step();
    test_back_to_back();
    test_auto();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
